// File: rtl/instruction_decode.sv
// Instruction decode stage: register file, branch/jump resolution, hazard stall, ID/EX register.
// Latency: branch/redirect/stall combinational; operands and fields registered, 1 cycle.
// Backpressure: o_stall holds fetch and loads a NOP bubble; ID_WB_BYPASS_EN selects WB forwarding vs WB stall.
module instruction_decode #(
  parameter int NB_DATA     = 32,
  parameter int NB_ADDRESS  = 32,
  parameter int NB_REG_ADDR = 5
) (
  input  logic                   i_clk,
  input  logic                   i_reset,
  input  logic [NB_DATA-1:0]     i_instruction,
  input  logic [NB_ADDRESS-1:0]  i_next_pc_1,
  input  logic                   i_wb_en,
  input  logic [NB_REG_ADDR-1:0] i_wb_addr,
  input  logic [NB_DATA-1:0]     i_wb_data,
  input  logic                   i_ex_mem_read,
  input  logic                   i_ex_wr_en,
  input  logic [NB_REG_ADDR-1:0] i_ex_wr_addr,
  input  logic                   i_mem_wr_en,
  input  logic [NB_REG_ADDR-1:0] i_mem_wr_addr,
  output logic                   o_branch,
  output logic [NB_ADDRESS-1:0]  o_branch_addr,
  output logic                   o_stall,
  output logic [NB_DATA-1:0]     o_rs_data,
  output logic [NB_DATA-1:0]     o_rt_data,
  output logic [NB_DATA-1:0]     o_imm_ext,
  output logic [NB_REG_ADDR-1:0] o_rs,
  output logic [NB_REG_ADDR-1:0] o_rt,
  output logic [NB_REG_ADDR-1:0] o_rd,
  output logic [5:0]             o_opcode,
  output logic [5:0]             o_funct,
  output logic [NB_ADDRESS-1:0]  o_next_pc_1
);

  localparam int N_REGS = 2**NB_REG_ADDR;

  localparam logic [5:0] OP_SPECIAL = 6'b000000;
  localparam logic [5:0] OP_J       = 6'b000010;
  localparam logic [5:0] OP_JAL     = 6'b000011;
  localparam logic [5:0] OP_BEQ     = 6'b000100;
  localparam logic [5:0] OP_BNE     = 6'b000101;
  localparam logic [5:0] FN_JR      = 6'b001000;
  localparam logic [5:0] FN_JALR    = 6'b001001;

  logic [NB_DATA-1:0] reg_file [N_REGS];

  // Instruction fields
  logic [5:0]             opcode;
  logic [5:0]             funct;
  logic [NB_REG_ADDR-1:0] rs;
  logic [NB_REG_ADDR-1:0] rt;
  logic [NB_REG_ADDR-1:0] rd;
  logic [15:0]            imm;
  logic [NB_DATA-1:0]     imm_ext;
  logic                   unused_shamt;

  assign opcode       = i_instruction[31:26];
  assign rs           = i_instruction[21 +: NB_REG_ADDR];
  assign rt           = i_instruction[16 +: NB_REG_ADDR];
  assign rd           = i_instruction[11 +: NB_REG_ADDR];
  assign funct        = i_instruction[5:0];
  assign imm          = i_instruction[15:0];
  assign imm_ext      = {{(NB_DATA-16){imm[15]}}, imm};
  assign unused_shamt = ^i_instruction[10:6];

  logic wb_write;
  assign wb_write = i_wb_en && (i_wb_addr != '0);

  logic [NB_DATA-1:0] rs_data;
  logic [NB_DATA-1:0] rt_data;

  // Combinational operand read; r0 is hardwired to zero
  always_comb begin
    rs_data = reg_file[rs];
    rt_data = reg_file[rt];
`ifdef ID_WB_BYPASS_EN
    if (wb_write && (i_wb_addr == rs)) rs_data = i_wb_data;
    if (wb_write && (i_wb_addr == rt)) rt_data = i_wb_data;
`endif
    if (rs == '0) rs_data = '0;
    if (rt == '0) rt_data = '0;
  end

  // Without forwarding, a same-cycle write-back to a source costs one retry cycle
  logic wb_hazard;
`ifdef ID_WB_BYPASS_EN
  assign wb_hazard = 1'b0;
`else
  assign wb_hazard = wb_write && ((i_wb_addr == rs) || (i_wb_addr == rt));
`endif

  logic is_cond_branch;
  logic is_jump_reg;
  logic rs_busy;
  logic rt_busy;
  logic load_use;
  logic branch_hazard;

  assign is_cond_branch = (opcode == OP_BEQ) || (opcode == OP_BNE);
  assign is_jump_reg    = (opcode == OP_SPECIAL) && ((funct == FN_JR) || (funct == FN_JALR));

  // Sources still being produced by EX or MEM cannot be compared in ID
  assign rs_busy = (rs != '0) && ((i_ex_wr_en && (i_ex_wr_addr == rs)) ||
                                  (i_mem_wr_en && (i_mem_wr_addr == rs)));
  assign rt_busy = (rt != '0) && ((i_ex_wr_en && (i_ex_wr_addr == rt)) ||
                                  (i_mem_wr_en && (i_mem_wr_addr == rt)));

  assign load_use = i_ex_mem_read && (i_ex_wr_addr != '0) &&
                    ((i_ex_wr_addr == rs) || (i_ex_wr_addr == rt));
  assign branch_hazard = (is_cond_branch && (rs_busy || rt_busy)) || (is_jump_reg && rs_busy);

  assign o_stall = !i_reset && (load_use || branch_hazard || wb_hazard);

  logic [NB_ADDRESS-1:0] br_target;
  logic [NB_ADDRESS-1:0] jump_target;
  logic                  branch_req;

  assign br_target   = i_next_pc_1 + {{(NB_ADDRESS-18){imm[15]}}, imm, 2'b00};
  assign jump_target = {i_next_pc_1[NB_ADDRESS-1:28], i_instruction[25:0], 2'b00};

  // Branch/jump resolution and redirect target selection
  always_comb begin
    branch_req    = 1'b0;
    o_branch_addr = br_target;
    case (opcode)
      OP_BEQ: branch_req = (rs_data == rt_data);
      OP_BNE: branch_req = (rs_data != rt_data);
      OP_J, OP_JAL: begin
        branch_req    = 1'b1;
        o_branch_addr = jump_target;
      end
      OP_SPECIAL: begin
        if (is_jump_reg) begin
          branch_req    = 1'b1;
          o_branch_addr = NB_ADDRESS'(rs_data);
        end
      end
      default: ;
    endcase
  end

  // Delay slot executes, so a redirect never flushes; it is only suppressed by stall/reset
  assign o_branch = branch_req && !o_stall && !i_reset;

  // Register file write port; r0 is never written
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      for (int i = 0; i < N_REGS; i++) reg_file[i] <= '0;
    end else if (wb_write) begin
      reg_file[i_wb_addr] <= i_wb_data;
    end
  end

  // ID/EX pipeline register; a stall loads the all-zero NOP bubble
  always_ff @(posedge i_clk) begin
    if (i_reset || o_stall) begin
      o_rs_data   <= '0;
      o_rt_data   <= '0;
      o_imm_ext   <= '0;
      o_rs        <= '0;
      o_rt        <= '0;
      o_rd        <= '0;
      o_opcode    <= '0;
      o_funct     <= '0;
      o_next_pc_1 <= '0;
    end else begin
      o_rs_data   <= rs_data;
      o_rt_data   <= rt_data;
      o_imm_ext   <= imm_ext;
      o_rs        <= rs;
      o_rt        <= rt;
      o_rd        <= rd;
      o_opcode    <= opcode;
      o_funct     <= funct;
      o_next_pc_1 <= i_next_pc_1;
    end
  end

endmodule

// File: tb/tb_instruction_decode.sv
// Bench for instruction_decode: directed scenarios plus randomized traffic against a reference model.
// Build with or without +define+ID_WB_BYPASS_EN; expectations follow the macro.
module tb_instruction_decode;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] instr;
  logic [31:0] next_pc;
  logic        wb_en;
  logic [4:0]  wb_addr;
  logic [31:0] wb_data;
  logic        ex_mem_read;
  logic        ex_wr_en;
  logic [4:0]  ex_wr_addr;
  logic        mem_wr_en;
  logic [4:0]  mem_wr_addr;

  logic        o_branch;
  logic [31:0] o_branch_addr;
  logic        o_stall;
  logic [31:0] o_rs_data, o_rt_data, o_imm_ext, o_next_pc_1;
  logic [4:0]  o_rs, o_rt, o_rd;
  logic [5:0]  o_opcode, o_funct;

  int total = 0;
  int bad   = 0;

  logic [31:0] mreg [32];

  always #5 clk = ~clk;

  instruction_decode dut (
    .i_clk(clk), .i_reset(reset), .i_instruction(instr), .i_next_pc_1(next_pc),
    .i_wb_en(wb_en), .i_wb_addr(wb_addr), .i_wb_data(wb_data),
    .i_ex_mem_read(ex_mem_read), .i_ex_wr_en(ex_wr_en), .i_ex_wr_addr(ex_wr_addr),
    .i_mem_wr_en(mem_wr_en), .i_mem_wr_addr(mem_wr_addr),
    .o_branch(o_branch), .o_branch_addr(o_branch_addr), .o_stall(o_stall),
    .o_rs_data(o_rs_data), .o_rt_data(o_rt_data), .o_imm_ext(o_imm_ext),
    .o_rs(o_rs), .o_rt(o_rt), .o_rd(o_rd), .o_opcode(o_opcode), .o_funct(o_funct),
    .o_next_pc_1(o_next_pc_1)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, got, want);
    end
  endtask

  function automatic logic [31:0] rtype(input int rs_i, input int rt_i, input int rd_i, input int fn);
    return (rs_i << 21) | (rt_i << 16) | (rd_i << 11) | fn;
  endfunction

  function automatic logic [31:0] itype(input int op, input int rs_i, input int rt_i, input int imm16);
    return (op << 26) | (rs_i << 21) | (rt_i << 16) | (imm16 & 32'hFFFF);
  endfunction

  function automatic logic [31:0] jtype(input int op, input int target);
    return (op << 26) | (target & 32'h03FF_FFFF);
  endfunction

  // Architectural register read as seen by decode this cycle
  function automatic logic [31:0] model_read(input logic [4:0] idx);
    if (idx == 0) return 32'h0;
`ifdef ID_WB_BYPASS_EN
    if (wb_en && wb_addr == idx) return wb_data;
`endif
    return mreg[idx];
  endfunction

  // One clock: check combinational outputs mid-cycle, then the ID/EX register after the edge
  task automatic cycle();
    int          op, fn;
    logic [4:0]  rs, rt, rd;
    logic [31:0] rsv, rtv, tgt, sx;
    bit          stall, br;
    logic [4:0]  used [$];
    logic [31:0] e_rsd, e_rtd, e_imm, e_pc;
    logic [4:0]  e_rs, e_rt, e_rd;
    int          e_op, e_fn;

    @(negedge clk);
    op  = int'(instr[31:26]);
    fn  = int'(instr[5:0]);
    rs  = instr[25:21];
    rt  = instr[20:16];
    rd  = instr[15:11];
    rsv = model_read(rs);
    rtv = model_read(rt);
    sx  = 32'($signed(instr[15:0]));
    stall = 1'b0;
    br    = 1'b0;
    tgt   = 32'h0;
    if (!reset) begin
      if (ex_mem_read && ex_wr_addr != 0 && (ex_wr_addr == rs || ex_wr_addr == rt)) stall = 1'b1;
      if (op == 4 || op == 5) used = '{rs, rt};
      else if (op == 0 && (fn == 8 || fn == 9)) used = '{rs};
      foreach (used[k])
        if (used[k] != 0 && ((ex_wr_en && used[k] == ex_wr_addr) || (mem_wr_en && used[k] == mem_wr_addr)))
          stall = 1'b1;
`ifndef ID_WB_BYPASS_EN
      if (wb_en && wb_addr != 0 && (wb_addr == rs || wb_addr == rt)) stall = 1'b1;
`endif
      case (op)
        4: begin br = (rsv == rtv); tgt = next_pc + sx * 4; end
        5: begin br = (rsv != rtv); tgt = next_pc + sx * 4; end
        2, 3: begin br = 1'b1; tgt = (next_pc & 32'hF000_0000) + ({6'b0, instr[25:0]} * 4); end
        0: if (fn == 8 || fn == 9) begin br = 1'b1; tgt = rsv; end
        default: ;
      endcase
      if (stall) br = 1'b0;
    end
    chk("stall", o_stall, stall);
    chk("branch", o_branch, br);
    if (br) chk("br_addr", o_branch_addr, tgt);

    if (reset || stall) begin
      e_rsd = 0; e_rtd = 0; e_imm = 0; e_pc = 0; e_rs = 0; e_rt = 0; e_rd = 0; e_op = 0; e_fn = 0;
    end else begin
      e_rsd = rsv; e_rtd = rtv; e_imm = sx; e_pc = next_pc; e_rs = rs; e_rt = rt; e_rd = rd;
      e_op = op; e_fn = fn;
    end

    if (reset) foreach (mreg[k]) mreg[k] = 32'h0;
    else if (wb_en && wb_addr != 0) mreg[wb_addr] = wb_data;

    @(posedge clk);
    #1;
    chk("rs_data", o_rs_data, e_rsd);
    chk("rt_data", o_rt_data, e_rtd);
    chk("imm_ext", o_imm_ext, e_imm);
    chk("rs", o_rs, e_rs);
    chk("rt", o_rt, e_rt);
    chk("rd", o_rd, e_rd);
    chk("opcode", o_opcode, 64'(e_op));
    chk("funct", o_funct, 64'(e_fn));
    chk("next_pc", o_next_pc_1, e_pc);
  endtask

  task automatic quiet();
    wb_en = 0; wb_addr = 0; wb_data = 0;
    ex_mem_read = 0; ex_wr_en = 0; ex_wr_addr = 0;
    mem_wr_en = 0; mem_wr_addr = 0;
  endtask

  task automatic write_reg(input int idx, input logic [31:0] val);
    quiet();
    instr = 32'h0; wb_en = 1; wb_addr = 5'(idx); wb_data = val;
    cycle();
    wb_en = 0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    foreach (mreg[k]) mreg[k] = 32'h0;
    reset = 1; instr = 0; next_pc = 0;
    quiet();
    cycle();
    // Reset must dominate hazard and branch conditions on the inputs
    instr = itype(4, 1, 1, 3); ex_mem_read = 1; ex_wr_en = 1; ex_wr_addr = 1; wb_en = 1; wb_addr = 1;
    cycle();
    reset = 0;
    quiet();

    // Write-back then ADD r3,r5,r0
    write_reg(5, 32'h7);
    instr = rtype(5, 0, 3, 6'h20);
    cycle();
    chk("add_rs_data", o_rs_data, 32'h7);
    chk("add_rt_data", o_rt_data, 32'h0);
    chk("add_rd", o_rd, 3);

    // BEQ r1,r2,-1 with equal operands
    write_reg(1, 32'h10);
    write_reg(2, 32'h10);
    instr = itype(4, 1, 2, 16'hFFFF); next_pc = 32'h40;
    cycle();
    chk("beq_taken", o_branch, 1);
    chk("beq_target", o_branch_addr, 32'h3C);

    // Load-use stall on ADD r6,r4,r2, then normal decode once the load moves on
    ex_mem_read = 1; ex_wr_en = 1; ex_wr_addr = 4;
    instr = rtype(4, 2, 6, 6'h20);
    cycle();
    chk("lu_stall", o_stall, 1);
    chk("lu_bubble_rd", o_rd, 0);
    chk("lu_bubble_op_fn", {o_opcode, o_funct}, 0);
    ex_mem_read = 0; ex_wr_en = 0;
    cycle();
    chk("lu_resume_rd", o_rd, 6);
    chk("lu_resume_rt", o_rt_data, 32'h10);

    // JAL target and link value
    instr = jtype(3, 26'h10); next_pc = 32'h1000_0008;
    cycle();
    chk("jal_target", o_branch_addr, 32'h1000_0040);
    chk("jal_link", o_next_pc_1, 32'h1000_0008);

    // Same-cycle write-back to a source register
    wb_en = 1; wb_addr = 9; wb_data = 32'hAB;
    instr = rtype(9, 0, 1, 6'h20);
    cycle();
`ifdef ID_WB_BYPASS_EN
    chk("wb_bypass_rs", o_rs_data, 32'hAB);
`else
    chk("wb_stall_bubble", o_rs_data, 32'h0);
    wb_en = 0;
    cycle();
    chk("wb_retry_rs", o_rs_data, 32'hAB);
`endif
    quiet();

    // Branch operand produced in MEM stalls BNE; JR with r0 never stalls
    mem_wr_en = 1; mem_wr_addr = 2;
    instr = itype(5, 1, 2, 16'h0004);
    cycle();
    instr = rtype(0, 0, 0, 6'h08);
    cycle();
    quiet();

    // Reset arriving during a stall
    ex_mem_read = 1; ex_wr_en = 1; ex_wr_addr = 1;
    instr = rtype(1, 2, 7, 6'h20);
    cycle();
    reset = 1;
    cycle();
    reset = 0; quiet();
    cycle();

    // Randomized traffic with small register indices so hazards and equal operands occur
    for (int n = 0; n < 400; n++) begin
      int op, fn, sel;
      reset = ($urandom_range(0, 60) == 0);
      sel = $urandom_range(0, 7);
      case (sel)
        0, 1: op = 0;
        2: op = 2;
        3: op = 3;
        4: op = 4;
        5: op = 5;
        6: op = 6'h23;
        default: op = $urandom_range(0, 63);
      endcase
      case ($urandom_range(0, 3))
        0: fn = 8;
        1: fn = 9;
        2: fn = 6'h20;
        default: fn = $urandom_range(0, 63);
      endcase
      instr = ($urandom & 32'h03FF_FFC0) | fn;
      instr[31:26] = 6'(op);
      instr[25:21] = 5'($urandom_range(0, 7));
      instr[20:16] = 5'($urandom_range(0, 7));
      next_pc = $urandom & 32'hFFFF_FFFC;
      wb_en = ($urandom_range(0, 2) == 0);
      wb_addr = 5'($urandom_range(0, 7));
      case ($urandom_range(0, 3))
        0: wb_data = 32'h0;
        1: wb_data = 32'h1;
        2: wb_data = 32'h10;
        default: wb_data = $urandom;
      endcase
      ex_mem_read = ($urandom_range(0, 3) == 0);
      ex_wr_en = ($urandom_range(0, 2) == 0);
      ex_wr_addr = 5'($urandom_range(0, 7));
      mem_wr_en = ($urandom_range(0, 2) == 0);
      mem_wr_addr = 5'($urandom_range(0, 7));
      cycle();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
